// File: rtl/led_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen_if
// Description : Status inputs and LED drive bundle for led_pattern_gen.
//               The master side supplies core status, the slave side drives
//               the LED bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_pattern_gen_if #(
  parameter int N_LED = 8
);
  logic             running;
  logic             done;
  logic [1:0]       mode;
  logic [N_LED-1:0] led;

  modport master (output running, output done, output mode, input led);
  modport slave  (input running, input done, input mode, output led);
endinterface
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen
// Description : LED status sequencer. Selects STOP / RUN / DONE from the core
//               status, animates an N_LED bank on a prescaled step tick and
//               drives registered, glitch-free LED outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
  parameter int N_LED       = 8,
  parameter int STEP_DIV    = 4_194_304,
  parameter int BLINK_STEPS = 16
) (
  input  logic               clk,
  input  logic               rst,
  led_pattern_gen_if.slave   bus
);

  localparam int PW = $clog2(N_LED);
  localparam int SW = $clog2(2 * N_LED);
  localparam int DW = $clog2(STEP_DIV);
  localparam int BW = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;

  localparam logic [PW-1:0]    POS_MAX   = PW'(N_LED - 1);
  localparam logic [SW-1:0]    STEP_MAX  = SW'(2 * N_LED - 1);
  localparam logic [SW-1:0]    STEP_HALF = SW'(N_LED);
  localparam logic [DW-1:0]    DIV_MAX   = DW'(STEP_DIV - 1);
  localparam logic [BW-1:0]    BLK_MAX   = BW'(BLINK_STEPS - 1);
  localparam logic [N_LED-1:0] ONE       = N_LED'(1);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_nx;
  logic [1:0]       mode_q;
  logic             restart;

  logic [DW-1:0]    div_cnt;
  logic             tick;
  logic [BW-1:0]    blk_cnt;
  logic             blink;
  logic             blink_nx;

  logic [PW-1:0]    pos;
  logic [PW-1:0]    pos_nx;
  logic             dir;          // 0 = up, 1 = down
  logic             dir_nx;
  logic [SW-1:0]    step;
  logic [SW-1:0]    step_nx;
  logic [N_LED-1:0] fill;
  logic [N_LED-1:0] fill_nx;

  logic [N_LED-1:0] bar_pat;
  logic [N_LED-1:0] odd_pat;
  logic [N_LED-1:0] led_nx;
  logic [N_LED-1:0] led_q;

  assign tick     = (div_cnt == DIV_MAX);
  assign blink_nx = blink ^ (tick && (blk_cnt == BLK_MAX));

  // Static odd-bit pattern and bar graph mask derived from the upcoming position
  for (genvar gi = 0; gi < N_LED; gi++) begin : g_pat
    assign odd_pat[gi] = ((gi % 2) == 1);
    assign bar_pat[gi] = (PW'(gi) <= pos_nx);
  end

  // Free-running step prescaler; never disturbed by state changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  // Blink phase counter, advanced by step ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
      blink   <= 1'b0;
    end else if (tick) begin
      blk_cnt <= (blk_cnt == BLK_MAX) ? '0 : blk_cnt + 1'b1;
      blink   <= blink_nx;
    end
  end

  // State register and remembered mode that together form the context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOP;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_nx;
      mode_q  <= bus.mode;
    end
  end

  // Next state, restart detection and animation datapath update
  always_comb begin
    state_nx = ST_STOP;
    pos_nx   = pos;
    dir_nx   = dir;
    step_nx  = step;
    fill_nx  = fill;

    if (bus.done) begin
      state_nx = ST_DONE;
    end else if (bus.running) begin
      state_nx = ST_RUN;
    end

    // DONE ignores mode, so a mode change there is not a context change
    restart = (state_nx != state_q) ||
              ((state_nx != ST_DONE) && (bus.mode != mode_q));

    if (restart) begin
      pos_nx  = '0;
      dir_nx  = 1'b0;
      step_nx = '0;
      fill_nx = '0;
    end else if (tick) begin
      case (state_nx)
        ST_RUN: begin
          case (bus.mode)
            2'b01: pos_nx = (pos == '0) ? POS_MAX : pos - 1'b1;
            2'b10: begin
              pos_nx = dir ? pos - 1'b1 : pos + 1'b1;
              // Turn around on the step that lands on an end LED
              if (pos_nx == POS_MAX) begin
                dir_nx = 1'b1;
              end else if (pos_nx == '0) begin
                dir_nx = 1'b0;
              end
            end
            default: pos_nx = (pos == POS_MAX) ? '0 : pos + 1'b1;
          endcase
        end
        ST_STOP: begin
          if (bus.mode[0]) begin
            if (step < STEP_HALF) begin
              fill_nx = fill | (ONE << step);
            end else begin
              fill_nx = fill & ~(ONE << (step - STEP_HALF));
            end
            step_nx = (step == STEP_MAX) ? '0 : step + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Animation registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos  <= '0;
      dir  <= 1'b0;
      step <= '0;
      fill <= '0;
    end else begin
      pos  <= pos_nx;
      dir  <= dir_nx;
      step <= step_nx;
      fill <= fill_nx;
    end
  end

  // LED pattern from the upcoming context so the register never shows a stale mix
  always_comb begin
    led_nx = '0;
    case (state_nx)
      ST_RUN:  led_nx = (bus.mode == 2'b11) ? bar_pat : (ONE << pos_nx);
      ST_STOP: led_nx = bus.mode[0] ? fill_nx : (blink_nx ? odd_pat : ~odd_pat);
      ST_DONE: led_nx = blink_nx ? '1 : '0;
      default: led_nx = '0;
    endcase
  end

  // Registered LED drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_nx;
    end
  end

  assign bus.led = led_q;

endmodule
`default_nettype wire
